// File: rtl/instr_loader.sv
// -----------------------------------------------------------------------------
// instr_loader
//   Boot loader that receives a byte stream and writes it into instruction
//   memory as 32-bit words. While loading, the core is held in reset.
//
//   Stream layout: 16-bit word count N (low byte first), then N words of four
//   bytes each, least significant byte first. When the checksum option is
//   enabled, one more byte follows: the 8-bit sum (mod 256) of all data bytes.
//
//   Build option: define LOADER_CHECKSUM_EN to enable the trailing checksum
//   byte. Without it the CSUM state is never entered and err is tied low.
//
// Parameters
//   INSTR_WORDS : instruction memory depth in 32-bit words (power of two)
//   ADDR_W      : word-address width
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   rst_n      : synchronous active-low reset
//   in_valid   : byte offered on in_data
//   in_data    : boot stream byte
//   in_ready   : loader accepts a byte (high in every loading state)
//   im_we      : one-cycle instruction-memory write strobe
//   im_addr    : word index of the write
//   im_wdata   : word to write
//   cpu_rst_n  : active-low hold for the core, released when the load is done
//   done       : load complete (sticky until reset)
//   err        : load failed (sticky until reset)
// -----------------------------------------------------------------------------
module instr_loader #(
    parameter int INSTR_WORDS = 64,
    parameter int ADDR_W      = $clog2(INSTR_WORDS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              cpu_rst_n,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        LEN_LO = 3'd0,
        LEN_HI = 3'd1,
        DATA   = 3'd2,
        CSUM   = 3'd3,
        DONE   = 3'd4,
        ERROR  = 3'd5
    } state_t;

    state_t            state_reg;
    logic [15:0]       count_reg;     // N, total words in the stream
    logic [15:0]       word_cnt_reg;  // words already written in this stream
    logic [ADDR_W-1:0] addr_reg;      // next word index, wraps naturally
    logic [1:0]        byte_cnt_reg;  // byte position inside the current word
    logic [23:0]       asm_reg;       // first three bytes of the current word
    logic              we_reg;
    logic [ADDR_W-1:0] waddr_reg;
    logic [31:0]       wdata_reg;
    logic              cpu_rst_n_reg;
    logic              done_reg;

    logic              xfer;
    logic [15:0]       len_full;

    assign xfer     = in_valid && in_ready;
    assign len_full = {in_data, count_reg[7:0]};

    // Ready is a pure decode of the state register: no backpressure while loading.
    assign in_ready  = (state_reg == LEN_LO) || (state_reg == LEN_HI) ||
                       (state_reg == DATA)   || (state_reg == CSUM);
    assign im_we     = we_reg;
    assign im_addr   = waddr_reg;
    assign im_wdata  = wdata_reg;
    assign cpu_rst_n = cpu_rst_n_reg;
    assign done      = done_reg;

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] sum_reg;
    logic       err_reg;
    assign err = err_reg;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= LEN_LO;
            count_reg     <= '0;
            word_cnt_reg  <= '0;
            addr_reg      <= '0;
            byte_cnt_reg  <= '0;
            asm_reg       <= '0;
            we_reg        <= 1'b0;
            waddr_reg     <= '0;
            wdata_reg     <= '0;
            cpu_rst_n_reg <= 1'b0;
            done_reg      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_reg       <= '0;
            err_reg       <= 1'b0;
`endif
        end else begin
            // Strobe is a single-cycle pulse; only the 4th data byte raises it.
            we_reg <= 1'b0;
            case (state_reg)
                LEN_LO: begin
                    if (xfer) begin
                        count_reg[7:0] <= in_data;
                        state_reg      <= LEN_HI;
                    end
                end
                LEN_HI: begin
                    if (xfer) begin
                        count_reg[15:8] <= in_data;
                        if (len_full != 16'd0) begin
                            state_reg <= DATA;
                        end else begin
`ifdef LOADER_CHECKSUM_EN
                            state_reg <= CSUM;
`else
                            state_reg     <= DONE;
                            done_reg      <= 1'b1;
                            cpu_rst_n_reg <= 1'b1;
`endif
                        end
                    end
                end
                DATA: begin
                    if (xfer) begin
`ifdef LOADER_CHECKSUM_EN
                        sum_reg <= sum_reg + in_data;
`endif
                        byte_cnt_reg <= byte_cnt_reg + 2'd1;
                        asm_reg      <= {in_data, asm_reg[23:8]};
                        if (byte_cnt_reg == 2'd3) begin
                            we_reg       <= 1'b1;
                            waddr_reg    <= addr_reg;
                            wdata_reg    <= {in_data, asm_reg};
                            addr_reg     <= addr_reg + 1'b1;
                            word_cnt_reg <= word_cnt_reg + 16'd1;
                            if (word_cnt_reg == count_reg - 16'd1) begin
`ifdef LOADER_CHECKSUM_EN
                                state_reg <= CSUM;
`else
                                state_reg     <= DONE;
                                done_reg      <= 1'b1;
                                cpu_rst_n_reg <= 1'b1;
`endif
                            end
                        end
                    end
                end
                CSUM: begin
`ifdef LOADER_CHECKSUM_EN
                    if (xfer) begin
                        if (in_data == sum_reg) begin
                            state_reg     <= DONE;
                            done_reg      <= 1'b1;
                            cpu_rst_n_reg <= 1'b1;
                        end else begin
                            state_reg <= ERROR;
                            err_reg   <= 1'b1;
                        end
                    end
`else
                    // Unreachable without the checksum option.
                    state_reg <= LEN_LO;
`endif
                end
                DONE:    state_reg <= DONE;
                ERROR:   state_reg <= ERROR;
                default: state_reg <= LEN_LO;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// -----------------------------------------------------------------------------
// tb_instr_loader
//   Directed testbench for instr_loader. Two instances share the input stream:
//   dut uses the default depth (64 words), dut4 uses a 4-word memory to cover
//   address wrap. Memory writes are captured into queues on the falling edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_instr_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  in_data;

    logic        in_ready,  im_we,  cpu_rst_n,  done,  err;
    logic [5:0]  im_addr;
    logic [31:0] im_wdata;
    logic        in_ready4, im_we4, cpu_rst_n4, done4, err4;
    logic [1:0]  im_addr4;
    logic [31:0] im_wdata4;

    int vectors     = 0;
    int miscompares = 0;

    int          wa[$];
    logic [31:0] wd[$];
    int          wa4[$];
    logic [31:0] wd4[$];
    logic [7:0]  stream[$];

    always #5 clk = ~clk;

    instr_loader dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
        .cpu_rst_n(cpu_rst_n), .done(done), .err(err)
    );

    instr_loader #(.INSTR_WORDS(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready4), .im_we(im_we4), .im_addr(im_addr4), .im_wdata(im_wdata4),
        .cpu_rst_n(cpu_rst_n4), .done(done4), .err(err4)
    );

    always @(negedge clk) begin
        if (im_we)  begin wa.push_back(int'(im_addr));   wd.push_back(im_wdata);   end
        if (im_we4) begin wa4.push_back(int'(im_addr4)); wd4.push_back(im_wdata4); end
    end

    task automatic clear_q();
        wa.delete(); wd.delete(); wa4.delete(); wd4.delete();
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        in_data  = 8'h00;
        rst_n    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_q();
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 8'hxx;
        for (int k = 0; k < gap; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Sends stream[]; with the checksum option, appends the data-byte sum plus
    // csum_delta (non-zero delta produces a deliberately wrong checksum).
    task automatic run_stream(input int gap, input logic [7:0] csum_delta);
        logic [7:0] s;
        s = 8'h00;
        for (int i = 0; i < stream.size(); i++) begin
            if (i >= 2) s = s + stream[i];
            send_byte(stream[i], gap);
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(s + csum_delta, gap);
`else
        s = s + csum_delta;
`endif
    endtask

    task automatic load_basic();
        stream = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hB3, 8'h00, 8'h21, 8'h00};
    endtask

    task automatic test_reset();
        do_reset();
        vectors++; if (im_we !== 1'b0) begin miscompares++; $display("FAIL reset_im_we got=%b exp=0", im_we); end
        vectors++; if (im_addr !== 6'd0) begin miscompares++; $display("FAIL reset_im_addr got=%0d exp=0", im_addr); end
        vectors++; if (im_wdata !== 32'h0) begin miscompares++; $display("FAIL reset_im_wdata got=%h exp=0", im_wdata); end
        vectors++; if (cpu_rst_n !== 1'b0) begin miscompares++; $display("FAIL reset_cpu_rst_n got=%b exp=0", cpu_rst_n); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got=%b exp=0", done); end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err got=%b exp=0", err); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        $display("test_reset: outputs checked after reset");
    endtask

    task automatic check_basic_result(input string tag);
        vectors++; if (wa.size() !== 2) begin miscompares++; $display("FAIL %s_write_count got=%0d exp=2", tag, wa.size()); end
        if (wa.size() == 2) begin
            vectors++; if (wa[0] !== 0 || wd[0] !== 32'h00000013) begin miscompares++; $display("FAIL %s_write0 got=%0d:%h exp=0:00000013", tag, wa[0], wd[0]); end
            vectors++; if (wa[1] !== 1 || wd[1] !== 32'h002100B3) begin miscompares++; $display("FAIL %s_write1 got=%0d:%h exp=1:002100b3", tag, wa[1], wd[1]); end
        end
        vectors++; if (done !== 1'b1 || cpu_rst_n !== 1'b1) begin miscompares++; $display("FAIL %s_done got done=%b cpu_rst_n=%b exp 1 1", tag, done, cpu_rst_n); end
        vectors++; if (in_ready !== 1'b0 || err !== 1'b0) begin miscompares++; $display("FAIL %s_final got in_ready=%b err=%b exp 0 0", tag, in_ready, err); end
    endtask

    task automatic test_basic();
        do_reset();
        load_basic();
        run_stream(0, 8'h00);
`ifndef LOADER_CHECKSUM_EN
        // Cycle after the last data byte: final write strobe is visible.
        vectors++; if (im_we !== 1'b1 || im_addr !== 6'd1 || im_wdata !== 32'h002100B3) begin miscompares++; $display("FAIL basic_last_write got we=%b addr=%0d data=%h exp 1 1 002100b3", im_we, im_addr, im_wdata); end
`endif
        @(posedge clk); #1;
        vectors++; if (im_we !== 1'b0) begin miscompares++; $display("FAIL basic_we_after got=%b exp=0", im_we); end
        check_basic_result("basic");
        $display("test_basic: %0d writes captured, done=%b", wa.size(), done);
    endtask

    task automatic test_gaps();
        do_reset();
        load_basic();
        run_stream(3, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        check_basic_result("gaps");
        $display("test_gaps: %0d writes captured, done=%b", wa.size(), done);
    endtask

    task automatic test_zero_len();
        do_reset();
        stream = '{8'h00, 8'h00};
        run_stream(0, 8'h00);
        vectors++; if (done !== 1'b1 || cpu_rst_n !== 1'b1) begin miscompares++; $display("FAIL zero_done got done=%b cpu_rst_n=%b exp 1 1", done, cpu_rst_n); end
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (wa.size() !== 0) begin miscompares++; $display("FAIL zero_no_write got=%0d exp=0", wa.size()); end
        $display("test_zero_len: done=%b writes=%0d", done, wa.size());
    endtask

    task automatic test_wrap();
        do_reset();
        stream = '{8'h05, 8'h00};
        for (int w = 1; w <= 5; w++) begin
            stream.push_back(8'(w)); stream.push_back(8'h00);
            stream.push_back(8'h00); stream.push_back(8'h00);
        end
        run_stream(0, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (wa4.size() !== 5) begin miscompares++; $display("FAIL wrap_count got=%0d exp=5", wa4.size()); end
        if (wa4.size() == 5) begin
            vectors++; if (wa4[3] !== 3 || wd4[3] !== 32'h00000004) begin miscompares++; $display("FAIL wrap_write3 got=%0d:%h exp=3:00000004", wa4[3], wd4[3]); end
            vectors++; if (wa4[4] !== 0 || wd4[4] !== 32'h00000005) begin miscompares++; $display("FAIL wrap_write4 got=%0d:%h exp=0:00000005", wa4[4], wd4[4]); end
        end
        vectors++; if (wa.size() !== 5 || wa[wa.size()-1] !== 4) begin miscompares++; $display("FAIL wrap_deep_last got count=%0d exp count 5 at addr 4", wa.size()); end
        vectors++; if (done4 !== 1'b1 || cpu_rst_n4 !== 1'b1) begin miscompares++; $display("FAIL wrap_done got done=%b cpu_rst_n=%b exp 1 1", done4, cpu_rst_n4); end
        $display("test_wrap: %0d writes on 4-word memory, done=%b", wa4.size(), done4);
    endtask

    task automatic test_mid_reset();
        do_reset();
        send_byte(8'h02, 0); send_byte(8'h00, 0);
        send_byte(8'h13, 0); send_byte(8'h00, 0);
        vectors++; if (done !== 1'b0 || cpu_rst_n !== 1'b0 || in_ready !== 1'b1) begin miscompares++; $display("FAIL midrst_partial got done=%b cpu_rst_n=%b in_ready=%b exp 0 0 1", done, cpu_rst_n, in_ready); end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        vectors++; if (wa.size() !== 0) begin miscompares++; $display("FAIL midrst_no_write got=%0d exp=0", wa.size()); end
        vectors++; if (im_we !== 1'b0 || im_addr !== 6'd0 || im_wdata !== 32'h0 || done !== 1'b0 || cpu_rst_n !== 1'b0) begin miscompares++; $display("FAIL midrst_outputs got we=%b addr=%0d data=%h done=%b cpu_rst_n=%b", im_we, im_addr, im_wdata, done, cpu_rst_n); end
        load_basic();
        run_stream(0, 8'h00);
        @(posedge clk); #1;
        check_basic_result("midrst");
        $display("test_mid_reset: %0d writes after replay, done=%b", wa.size(), done);
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        do_reset();
        load_basic();
        run_stream(0, 8'h00);
        vectors++; if (done !== 1'b1 || err !== 1'b0) begin miscompares++; $display("FAIL csum_good got done=%b err=%b exp 1 0", done, err); end
        do_reset();
        load_basic();
        run_stream(0, 8'hFF); // E7 + FF = E6
        @(posedge clk); #1;
        vectors++; if (err !== 1'b1 || done !== 1'b0 || cpu_rst_n !== 1'b0 || in_ready !== 1'b0) begin miscompares++; $display("FAIL csum_bad got err=%b done=%b cpu_rst_n=%b in_ready=%b exp 1 0 0 0", err, done, cpu_rst_n, in_ready); end
        $display("test_checksum: bad checksum err=%b", err);
    endtask
`endif

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        test_reset();
        test_basic();
        test_gaps();
        test_zero_len();
        test_wrap();
        test_mid_reset();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 SHALL have parameter INSTR_WORDS, default 64: instruction memory depth in 32-bit words (power of two).
REQ-002 SHALL have parameter ADDR_W, default $clog2(INSTR_WORDS): word-address width.
REQ-003 SHALL have port clk  input  1: single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1: reset, synchronous, active-low.
REQ-005 SHALL have port in_valid  input  1: byte offered on in_data.
REQ-006 SHALL have port in_data  input  8: boot stream byte.
REQ-007 SHALL have port in_ready  output  1: loader accepts the byte; a transfer occurs when in_valid && in_ready at a rising edge.
REQ-008 SHALL have port im_we  output  1: instruction-memory word write strobe, one cycle.
REQ-009 SHALL have port im_addr  output  ADDR_W: word index for the write.
REQ-010 SHALL have port im_wdata  output  32: word to write.
REQ-011 SHALL have port cpu_rst_n  output  1: active-low hold for the core; low until the load completes.
REQ-012 SHALL have port done  output  1: load complete, sticky.
REQ-013 SHALL have port err  output  1: load failed, sticky.

Function
REQ-014 Stream format SHALL be: 16-bit word count N (low byte first), then N words of 4 bytes each, little-endian (first byte = bits 7:0).
REQ-015 FSM states SHALL be LEN_LO, LEN_HI, DATA, CSUM, DONE, ERROR.
REQ-016 LEN_LO SHALL capture count[7:0] on transfer, then go to LEN_HI.
REQ-017 LEN_HI SHALL capture count[15:8] on transfer, then go to DATA if N!=0, else to CSUM (macro on) or DONE (macro off).
REQ-018 DATA SHALL shift bytes into a 32-bit assembly register and count bytes 0-3.
REQ-019 On the 4th byte transfer, the cycle after the edge SHALL show im_we=1, im_wdata=assembled word, im_addr=current word index; the index then increments.
REQ-020 im_addr SHALL wrap modulo INSTR_WORDS; if N>INSTR_WORDS, later words overwrite earlier ones.
REQ-021 After word N is written, the FSM SHALL go to CSUM (macro on) or DONE (macro off).
REQ-022 in_ready SHALL be 1 in LEN_LO, LEN_HI, DATA and CSUM, and 0 in DONE and ERROR; there is no backpressure while loading.
REQ-023 Cycles with in_valid=0 SHALL leave all state unchanged; gaps of any length are legal.
REQ-024 DONE SHALL set done=1 and cpu_rst_n=1 from the first cycle in DONE; both outputs are registered.
REQ-025 DONE and ERROR SHALL be absorbing; only rst_n leaves them.
REQ-026 im_we SHALL be 0 in every cycle not covered by REQ-019.

Reset
REQ-027 While rst_n=0 at a rising edge, the block SHALL set: state=LEN_LO, word index=0, byte count=0, im_we=0, im_addr=0, im_wdata=0, cpu_rst_n=0, done=0, err=0, checksum=0.
REQ-028 Reset during a load SHALL discard the partial word; words already written stay in memory; the next stream loads from address 0.

Configuration
REQ-029 With macro LOADER_CHECKSUM_EN defined: an 8-bit running sum (mod 256) of all data bytes (not the length bytes) SHALL be kept. CSUM SHALL accept one byte: match -> DONE; mismatch -> ERROR (err=1, cpu_rst_n stays 0). N=0 also passes through CSUM, where the expected byte is 00.
REQ-030 Without LOADER_CHECKSUM_EN: no checksum logic, CSUM is unreachable, and err SHALL be tied 0.

Verification
REQ-031 Stream 02 00 13 00 00 00 B3 00 21 00 (macro off) -> im_we at addr 0 = 00000013, then addr 1 = 002100B3; done=1 and cpu_rst_n=1 on the cycle after the final write; in_ready=0 afterwards.
REQ-032 Same stream with in_valid low for 3 cycles between every byte -> the same two writes only, no extra im_we, same final state.
REQ-033 Stream 00 00 (macro off) -> no im_we; done=1 the cycle after the second byte.
REQ-034 INSTR_WORDS=4, N=5, words 1..5 -> the 5th write goes to im_addr 0 with data 00000005; done=1.
REQ-035 rst_n pulsed low after 2 data bytes of REQ-031 -> no im_we, outputs as in REQ-027; the full REQ-031 stream replayed then reproduces the REQ-031 result.
REQ-036 Macro on: REQ-031 stream + checksum E7 -> done=1, err=0; same stream + checksum E6 -> err=1, done=0, cpu_rst_n=0, in_ready=0.
